// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for the seven-segment scan controller: load strobe/data in, pin drive out.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe, outputs are free-running.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  // Host side: drives control and digit data, observes the pins.
  modport master (
    output enable, load, load_data, load_dp,
    input  seg, dp, an, frame_done
  );

  // Controller side.
  modport slave (
    input  enable, load, load_data, load_dp,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-seg scanner with double-buffered BCD digits.
// Latency: outputs registered; a load becomes visible in the frame after the next commit.
// Backpressure: none; loads always accepted, last load before a commit wins.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic           clk,
  input logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_DARK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state;
  logic [DW-1:0]           digit;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  logic blank_last;
  logic slot_last;
  logic last_digit;
  logic commit;

  // Active-low segment patterns; anything outside 0..9 is left unlit.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = SEG_DARK;
    endcase
    return s;
  endfunction

  assign blank_last = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_last  = (cnt == CW'(REFRESH_DIV - 1));
  assign last_digit = (digit == DW'(NUM_DIGITS - 1));

  // Buffers swap at frame start (leaving IDLE) and when the last slot of a frame ends.
  assign commit = bus.enable &&
                  ((state == IDLE) || ((state == SHOW) && slot_last && last_digit));

  // Scan FSM: walks blank/show slots per digit and registers the pin drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      digit        <= '0;
      cnt          <= '0;
      seg_q        <= SEG_DARK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        digit <= '0;
        cnt   <= '0;
        seg_q <= SEG_DARK;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            digit <= '0;
            cnt   <= '0;
            seg_q <= SEG_DARK;
            dp_q  <= 1'b1;
            an_q  <= '1;
          end
          BLANK: begin
            cnt <= cnt + CW'(1);
            if (blank_last) begin
              state <= SHOW;
              seg_q <= decode(disp_data[{digit, 2'b00} +: 4]);
              dp_q  <= ~disp_dp[digit];
              an_q  <= ~(NUM_DIGITS'(1) << digit);
            end
          end
          SHOW: begin
            if (slot_last) begin
              state <= BLANK;
              cnt   <= '0;
              seg_q <= SEG_DARK;
              dp_q  <= 1'b1;
              an_q  <= '1;
              if (last_digit) begin
                digit        <= '0;
                frame_done_q <= 1'b1;
              end else begin
                digit <= digit + DW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            digit <= '0;
            cnt   <= '0;
            seg_q <= SEG_DARK;
            dp_q  <= 1'b1;
            an_q  <= '1;
          end
        endcase
      end
    end
  end

  // Pending/display double buffer; a load landing on a commit bypasses straight to display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
    end else if (commit) begin
      pend_valid <= 1'b0;
      if (bus.load) begin
        pend_data <= bus.load_data;
        pend_dp   <= bus.load_dp;
        disp_data <= bus.load_data;
        disp_dp   <= bus.load_dp;
      end else if (pend_valid) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
    end else if (bus.load) begin
      pend_data  <= bus.load_data;
      pend_dp    <= bus.load_dp;
      pend_valid <= 1'b1;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, hand-written corner sequences, random run vs. a frame-position model.
// Latency: model predicts outputs one edge after inputs are sampled.
// Backpressure: none.
module tb_seg_scan_ctrl;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus();

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: position within the frame plus the two buffers.
  bit         m_run;
  int         m_pos;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pend_dp, m_disp_dp;
  bit         m_pv, m_fd;

  logic [6:0] seg_tab [10];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    if (n < 4'd10) return seg_tab[n];
    return 7'b1111111;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_pend = '0; m_disp = '0;
    m_pend_dp = '0; m_disp_dp = '0; m_pv = 0; m_fd = 0;
  endtask

  task automatic model_commit();
    if (bus.load) begin
      m_disp = bus.load_data; m_disp_dp = bus.load_dp; m_pv = 0;
    end else if (m_pv) begin
      m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 0;
    end
  endtask

  task automatic model_edge();
    bit commit_now;
    commit_now = 0;
    m_fd = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bus.enable) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; commit_now = 1;
    end else begin
      m_pos++;
      if (m_pos == N * R) begin
        m_pos = 0; m_fd = 1; commit_now = 1;
      end
    end
    if (commit_now) model_commit();
    else if (bus.load) begin
      m_pend = bus.load_data; m_pend_dp = bus.load_dp; m_pv = 1;
    end
  endtask

  task automatic check_model();
    int slot, off;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    slot = m_pos / R;
    off  = m_pos % R;
    e_an = 4'hF; e_seg = 7'b1111111; e_dp = 1'b1;
    if (m_run && off >= B) begin
      e_an  = ~(4'b0001 << slot);
      e_seg = seg_of(m_disp[slot*4 +: 4]);
      e_dp  = ~m_disp_dp[slot];
    end
    check("m_an",  {12'h0, bus.an},         {12'h0, e_an});
    check("m_seg", {9'h0, bus.seg},         {9'h0, e_seg});
    check("m_dp",  {15'h0, bus.dp},         {15'h0, e_dp});
    check("m_fd",  {15'h0, bus.frame_done}, {15'h0, m_fd});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit en_r;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
    vecs[0]  = '{16'h1234, 4'b0001, 0, 4'b1110, 7'b1001100, 1'b0};
    vecs[1]  = '{16'h1234, 4'b0001, 1, 4'b1101, 7'b0000110, 1'b1};
    vecs[2]  = '{16'h1234, 4'b0001, 2, 4'b1011, 7'b0010010, 1'b1};
    vecs[3]  = '{16'h1234, 4'b0001, 3, 4'b0111, 7'b1001111, 1'b1};
    vecs[4]  = '{16'hF9A0, 4'b0000, 0, 4'b1110, 7'b0000001, 1'b1};
    vecs[5]  = '{16'hF9A0, 4'b0000, 1, 4'b1101, 7'b1111111, 1'b1};
    vecs[6]  = '{16'hF9A0, 4'b0000, 2, 4'b1011, 7'b0001100, 1'b1};
    vecs[7]  = '{16'hF9A0, 4'b0000, 3, 4'b0111, 7'b1111111, 1'b1};
    vecs[8]  = '{16'h5678, 4'b1010, 0, 4'b1110, 7'b0000000, 1'b1};
    vecs[9]  = '{16'h5678, 4'b1010, 1, 4'b1101, 7'b0001111, 1'b0};
    vecs[10] = '{16'h5678, 4'b1010, 2, 4'b1011, 7'b0100000, 1'b1};
    vecs[11] = '{16'h5678, 4'b1010, 3, 4'b0111, 7'b0100100, 1'b0};

    bus.enable = 1'b1; bus.load = 1'b0; bus.load_data = '0; bus.load_dp = '0;
    model_reset();

    // Reset held with enable high: dark throughout.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_an",  {12'h0, bus.an},  16'h000F);
      check("rst_seg", {9'h0, bus.seg},  16'h007F);
      check("rst_dp",  {15'h0, bus.dp},  16'h0001);
      check("rst_fd",  {15'h0, bus.frame_done}, 16'h0000);
    end
    bus.enable = 1'b0;
    rst = 1'b0;
    tick();

    // Table: per-digit decode, anode walk and dp after load in IDLE.
    for (int v = 0; v < 12; v++) begin
      bus.enable = 1'b0;
      apply_reset();
      bus.load = 1'b1; bus.load_data = vecs[v].data; bus.load_dp = vecs[v].dpv;
      tick();
      bus.load = 1'b0; bus.enable = 1'b1;
      tick();
      adv(vecs[v].digit * R + B + 1);
      check("tbl_an",  {12'h0, bus.an}, {12'h0, vecs[v].an});
      check("tbl_seg", {9'h0, bus.seg}, {9'h0, vecs[v].seg});
      check("tbl_dp",  {15'h0, bus.dp}, {15'h0, vecs[v].dp});
    end

    // Mid-frame load holds until frame end; load in the frame_done cycle waits a frame.
    bus.enable = 1'b0;
    apply_reset();
    bus.load = 1'b1; bus.load_data = 16'h1234; bus.load_dp = 4'b0001;
    tick();
    bus.load = 1'b0; bus.enable = 1'b1;
    tick();
    check("start_dark", {12'h0, bus.an}, 16'h000F);
    adv(1);
    check("blank2_dark", {12'h0, bus.an}, 16'h000F);
    adv(1);
    check("first_show", {9'h0, bus.seg}, 16'h004C);
    adv(8);
    bus.load = 1'b1; bus.load_data = 16'h5678; bus.load_dp = 4'b0000;
    tick();
    bus.load = 1'b0;
    adv(8);
    check("midload_old", {9'h0, bus.seg}, 16'h0012);
    adv(12);
    check("fd_before", {15'h0, bus.frame_done}, 16'h0000);
    tick();
    check("fd_pulse", {15'h0, bus.frame_done}, 16'h0001);
    bus.load = 1'b1; bus.load_data = 16'h4321; bus.load_dp = 4'b0000;
    tick();
    check("fd_after", {15'h0, bus.frame_done}, 16'h0000);
    bus.load = 1'b0;
    adv(2);
    check("new_frame", {9'h0, bus.seg}, 16'h0000);
    adv(29);
    adv(3);
    check("fd_load", {9'h0, bus.seg}, 16'h004F);

    // Drop enable during digit-2 SHOW, then restart from digit 0.
    adv(16);
    check("d2_an", {12'h0, bus.an}, 16'h000B);
    bus.enable = 1'b0;
    tick();
    check("drop_an",  {12'h0, bus.an}, 16'h000F);
    check("drop_seg", {9'h0, bus.seg}, 16'h007F);
    adv(3);
    bus.enable = 1'b1;
    adv(2);
    check("restart_dark", {12'h0, bus.an}, 16'h000F);
    tick();
    check("restart_an", {12'h0, bus.an}, 16'h000E);

    // Asynchronous reset mid-SHOW: dark before the next edge, buffer cleared.
    adv(2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_an",  {12'h0, bus.an}, 16'h000F);
    check("arst_seg", {9'h0, bus.seg}, 16'h007F);
    check("arst_dp",  {15'h0, bus.dp}, 16'h0001);
    model_reset();
    tick();
    rst = 1'b0;
    adv(3);
    check("cleared_seg", {9'h0, bus.seg}, 16'h0001);
    check("cleared_an",  {12'h0, bus.an}, 16'h000E);

    // Random run against the model.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      bus.enable    = en_r;
      bus.load      = ($urandom_range(0, 99) < 8);
      bus.load_data = 16'($urandom);
      bus.load_dp   = 4'($urandom);
      if ($urandom_range(0, 599) == 0) apply_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
